// File: rtl/dht11_read_sequencer.sv
// DHT11 host sequencer: issues the start pulse, times response and 40 data bits, checks the sum.
// Launches on start, a pending request or the poll timer; a holdoff separates transactions.
module dht11_read_sequencer #(
    parameter int START_LOW_CYC  = 18000,
    parameter int RELEASE_CYC    = 30,
    parameter int BIT_THRESH_CYC = 48,
    parameter int TIMEOUT_CYC    = 200,
    parameter int HOLDOFF_CYC    = 1000000,
    parameter int POLL_CYC       = 2000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       auto_en,
    input  logic       dht_in,
    output logic       dht_oe,
    output logic       busy,
    output logic       valid,
    output logic [7:0] humidity,
    output logic [7:0] temperature,
    output logic       err_timeout,
    output logic       err_checksum
);
    localparam int PH_MAX0 = (START_LOW_CYC > RELEASE_CYC) ? START_LOW_CYC : RELEASE_CYC;
    localparam int PH_MAX  = (PH_MAX0 > TIMEOUT_CYC) ? PH_MAX0 : TIMEOUT_CYC;
    localparam int PH_W    = $clog2(PH_MAX + 1);
    localparam int HO_W    = $clog2(HOLDOFF_CYC + 1);
    localparam int PO_W    = $clog2(POLL_CYC + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_START_LOW, S_RELEASE, S_RESP_LO, S_RESP_HI,
        S_RESP_END, S_BIT_LO, S_BIT_HI, S_CHECK
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        sync_q, sync_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [HO_W-1:0]   holdoff_q, holdoff_d;
    logic [PO_W-1:0]   poll_q, poll_d;
    logic              poll_due_q, poll_due_d;
    logic              pending_q, pending_d;
    logic [5:0]        bit_cnt_q, bit_cnt_d;
    logic [39:0]       data_q, data_d;
    logic [7:0]        hum_q, hum_d, tmp_q, tmp_d;
    logic              valid_q, valid_d, err_to_q, err_to_d, err_ck_q, err_ck_d;
    logic              oe_q, oe_d, busy_q, busy_d;

    logic       rise, fall, launch, waiting, timeout, bit_val;
    logic [7:0] sum;

    // sync_q[1] is the synchronized pad, sync_q[2] its previous value
    assign rise    = sync_q[1] & ~sync_q[2];
    assign fall    = ~sync_q[1] & sync_q[2];
    assign launch  = (state_q == S_IDLE) && (start || pending_q || poll_due_q) && (holdoff_q == '0);
    assign waiting = (state_q inside {S_RESP_LO, S_RESP_HI, S_RESP_END, S_BIT_LO, S_BIT_HI});
    // phase restarts one cycle after the rise, so phase+1 is the synchronized high time
    assign bit_val = (phase_q >= PH_W'(BIT_THRESH_CYC));
    assign sum     = data_q[39:32] + data_q[31:24] + data_q[23:16] + data_q[15:8];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            sync_q     <= '1;
            phase_q    <= '0;
            holdoff_q  <= '0;
            poll_q     <= '0;
            poll_due_q <= 1'b0;
            pending_q  <= 1'b0;
            bit_cnt_q  <= '0;
            data_q     <= '0;
            hum_q      <= '0;
            tmp_q      <= '0;
            valid_q    <= 1'b0;
            err_to_q   <= 1'b0;
            err_ck_q   <= 1'b0;
            oe_q       <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            phase_q    <= phase_d;
            holdoff_q  <= holdoff_d;
            poll_q     <= poll_d;
            poll_due_q <= poll_due_d;
            pending_q  <= pending_d;
            bit_cnt_q  <= bit_cnt_d;
            data_q     <= data_d;
            hum_q      <= hum_d;
            tmp_q      <= tmp_d;
            valid_q    <= valid_d;
            err_to_q   <= err_to_d;
            err_ck_q   <= err_ck_d;
            oe_q       <= oe_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timeout = 1'b0;
        case (state_q)
            S_IDLE:      if (launch) state_d = S_START_LOW;
            S_START_LOW: if (phase_q == PH_W'(START_LOW_CYC - 1)) state_d = S_RELEASE;
            S_RELEASE:   if (phase_q == PH_W'(RELEASE_CYC - 1)) state_d = S_RESP_LO;
            S_RESP_LO:   if (fall) state_d = S_RESP_HI;
            S_RESP_HI:   if (rise) state_d = S_RESP_END;
            S_RESP_END:  if (fall) state_d = S_BIT_LO;
            S_BIT_LO:    if (rise) state_d = S_BIT_HI;
            S_BIT_HI:    if (fall) state_d = (bit_cnt_q == 6'd39) ? S_CHECK : S_BIT_LO;
            S_CHECK:     state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
        if (waiting && (state_d == state_q) && (phase_q == PH_W'(TIMEOUT_CYC - 1))) begin
            timeout = 1'b1;
            state_d = S_IDLE;
        end
    end

    always_comb begin
        sync_d = {sync_q[1:0], dht_in};

        if (state_d != state_q)              phase_d = '0;
        else if (phase_q == PH_W'(PH_MAX))   phase_d = phase_q;
        else                                 phase_d = phase_q + PH_W'(1);

        holdoff_d = holdoff_q;
        if (state_q != S_IDLE && state_d == S_IDLE) holdoff_d = HO_W'(HOLDOFF_CYC);
        else if (holdoff_q != '0)                   holdoff_d = holdoff_q - HO_W'(1);

        pending_d = pending_q;
        if (launch)                                                    pending_d = 1'b0;
        else if (start && state_q == S_IDLE && holdoff_q != '0)        pending_d = 1'b1;

        // poll period runs start-to-start: the launch cycle counts as the first cycle
        poll_d     = poll_q;
        poll_due_d = poll_due_q;
        if (!auto_en) begin
            poll_d     = '0;
            poll_due_d = 1'b0;
        end else if (launch) begin
            poll_d     = PO_W'(1);
            poll_due_d = 1'b0;
        end else if (poll_q >= PO_W'(POLL_CYC - 1)) begin
            poll_due_d = 1'b1;
        end else begin
            poll_d = poll_q + PO_W'(1);
        end

        bit_cnt_d = bit_cnt_q;
        data_d    = data_q;
        if (launch) begin
            bit_cnt_d = '0;
            data_d    = '0;
        end else if (state_q == S_BIT_HI && fall) begin
            data_d = {data_q[38:0], bit_val};
            if (bit_cnt_q != 6'h3f) bit_cnt_d = bit_cnt_q + 6'd1;
        end

        hum_d    = hum_q;
        tmp_d    = tmp_q;
        valid_d  = 1'b0;
        err_ck_d = 1'b0;
        err_to_d = timeout;
        if (state_q == S_CHECK) begin
            if (sum == data_q[7:0]) begin
                hum_d   = data_q[39:32];
                tmp_d   = data_q[23:16];
                valid_d = 1'b1;
            end else begin
                err_ck_d = 1'b1;
            end
        end

        oe_d   = (state_d == S_START_LOW);
        busy_d = (state_d != S_IDLE);
    end

    assign dht_oe       = oe_q;
    assign busy         = busy_q;
    assign valid        = valid_q;
    assign humidity     = hum_q;
    assign temperature  = tmp_q;
    assign err_timeout  = err_to_q;
    assign err_checksum = err_ck_q;
endmodule

// File: tb/tb_dht11_read_sequencer.sv
// Directed bench for dht11_read_sequencer with a simple open-drain DHT11 sensor model.
module tb_dht11_read_sequencer;
    localparam int START_LOW_CYC  = 20;
    localparam int RELEASE_CYC    = 3;
    localparam int BIT_THRESH_CYC = 5;
    localparam int TIMEOUT_CYC    = 15;
    localparam int HOLDOFF_CYC    = 50;
    localparam int POLL_CYC       = 400;

    logic       clk = 1'b0;
    logic       reset, start, auto_en, sens_line;
    logic       dht_in, dht_oe, busy, valid, err_timeout, err_checksum;
    logic [7:0] humidity, temperature;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // open-drain pad: host pulls low, otherwise the sensor (or the pull-up) sets the level
    assign dht_in = dht_oe ? 1'b0 : sens_line;

    dht11_read_sequencer #(
        .START_LOW_CYC (START_LOW_CYC),
        .RELEASE_CYC   (RELEASE_CYC),
        .BIT_THRESH_CYC(BIT_THRESH_CYC),
        .TIMEOUT_CYC   (TIMEOUT_CYC),
        .HOLDOFF_CYC   (HOLDOFF_CYC),
        .POLL_CYC      (POLL_CYC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .auto_en     (auto_en),
        .dht_in      (dht_in),
        .dht_oe      (dht_oe),
        .busy        (busy),
        .valid       (valid),
        .humidity    (humidity),
        .temperature (temperature),
        .err_timeout (err_timeout),
        .err_checksum(err_checksum)
    );

    int   cyc = 0;
    int   n_valid = 0, n_cks = 0, n_to = 0, n_oe_rise = 0, oe_hi = 0;
    int   oe_rise_cyc = 0, oe_fall_cyc = 0, busy_fall_cyc = 0, to_cyc = 0;
    int   rise_at [32];
    logic oe_prev = 1'b0, busy_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        oe_prev   <= dht_oe;
        busy_prev <= busy;
        if (valid)        n_valid <= n_valid + 1;
        if (err_checksum) n_cks   <= n_cks + 1;
        if (err_timeout) begin
            n_to   <= n_to + 1;
            to_cyc <= cyc;
        end
        if (dht_oe) oe_hi <= oe_hi + 1;
        if (dht_oe && !oe_prev) begin
            n_oe_rise   <= n_oe_rise + 1;
            oe_rise_cyc <= cyc;
            if (n_oe_rise < 32) rise_at[n_oe_rise] <= cyc;
        end
        if (!dht_oe && oe_prev) oe_fall_cyc   <= cyc;
        if (!busy && busy_prev) busy_fall_cyc <= cyc;
    end

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic pick(input int sel);
        case (sel)
            0:       return dht_oe;
            1:       return busy;
            default: return err_timeout;
        endcase
    endfunction

    // bounded wait for a DUT output to reach a level; expiry shows up as a failed check
    task automatic wait_lvl(input int sel, input logic lvl, input int budget, input string tag);
        int k = 0;
        while (pick(sel) !== lvl && k < budget) begin
            @(negedge clk);
            k++;
        end
        #1;
        check(tag, int'(pick(sel)), int'(lvl));
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // sensor: 8 low / 8 high response, then per bit 5 low and 3 (zero) or 8 (one) high
    task automatic sensor_reply(input logic [39:0] frame, input int nbits);
        wait_lvl(0, 1'b1, 200, "sens_oe_rise");
        wait_lvl(0, 1'b0, START_LOW_CYC + 10, "sens_oe_fall");
        repeat (5) @(negedge clk);
        sens_line = 1'b0;
        repeat (8) @(negedge clk);
        sens_line = 1'b1;
        repeat (8) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            sens_line = 1'b0;
            repeat (5) @(negedge clk);
            sens_line = 1'b1;
            repeat (frame[39-i] ? 8 : 3) @(negedge clk);
        end
        if (nbits == 40) begin
            sens_line = 1'b0;
            repeat (5) @(negedge clk);
            sens_line = 1'b1;
        end
    endtask

    initial begin
        int s_valid, s_cks, s_to, s_oe, n0, n1, d;
        logic [39:0] frame;

        reset = 1'b1; start = 1'b0; auto_en = 1'b0; sens_line = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_oe", int'(dht_oe), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_hum", int'(humidity), 0);
        check("rst_tmp", int'(temperature), 0);
        check("rst_errto", int'(err_timeout), 0);
        check("rst_errck", int'(err_checksum), 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // 1: good frame 37 00 19 00 50
        s_valid = n_valid; s_cks = n_cks; s_to = n_to; s_oe = oe_hi;
        pulse_start();
        frame = 40'h37_00_19_00_50;
        sensor_reply(frame, 40);
        wait_lvl(1, 1'b0, 60, "t1_busy_low");
        check("t1_oe_cycles", oe_hi - s_oe, 20);
        check("t1_oe_width", oe_fall_cyc - oe_rise_cyc, 20);
        check("t1_valid_cnt", n_valid - s_valid, 1);
        check("t1_cks_cnt", n_cks - s_cks, 0);
        check("t1_to_cnt", n_to - s_to, 0);
        check("t1_hum", int'(humidity), 'h37);
        check("t1_tmp", int'(temperature), 'h19);

        // 2: bad checksum 37 00 19 00 51, launched from pending during holdoff
        s_valid = n_valid; s_cks = n_cks; s_to = n_to;
        pulse_start();
        frame = 40'h37_00_19_00_51;
        sensor_reply(frame, 40);
        wait_lvl(1, 1'b0, 60, "t2_busy_low");
        check("t2_cks_cnt", n_cks - s_cks, 1);
        check("t2_valid_cnt", n_valid - s_valid, 0);
        check("t2_to_cnt", n_to - s_to, 0);
        check("t2_hum", int'(humidity), 'h37);
        check("t2_tmp", int'(temperature), 'h19);

        // 3: no sensor, timeout RELEASE_CYC + TIMEOUT_CYC after the release
        s_valid = n_valid; s_cks = n_cks; s_to = n_to;
        pulse_start();
        wait_lvl(0, 1'b1, 200, "t3_oe_rise");
        wait_lvl(0, 1'b0, START_LOW_CYC + 10, "t3_oe_fall");
        wait_lvl(2, 1'b1, 60, "t3_errto");
        check("t3_to_delay", to_cyc - oe_fall_cyc, RELEASE_CYC + TIMEOUT_CYC);
        check("t3_busy", int'(busy), 0);
        check("t3_oe", int'(dht_oe), 0);
        check("t3_busy_fall", busy_fall_cyc, to_cyc);
        check("t3_to_cnt", n_to - s_to, 1);
        check("t3_other_cnt", (n_valid - s_valid) + (n_cks - s_cks), 0);
        check("t3_hum", int'(humidity), 'h37);

        // 4: reset during bit 20, then a full frame with a wrapping checksum
        pulse_start();
        frame = 40'hC8_40_50_20_78;
        sensor_reply(frame, 19);
        sens_line = 1'b0;
        repeat (5) @(negedge clk);
        sens_line = 1'b1;
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("t4_oe", int'(dht_oe), 0);
        check("t4_busy", int'(busy), 0);
        check("t4_hum", int'(humidity), 0);
        check("t4_tmp", int'(temperature), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        s_valid = n_valid; s_cks = n_cks;
        pulse_start();
        sensor_reply(frame, 40);
        wait_lvl(1, 1'b0, 60, "t4_busy_low");
        check("t4_valid_cnt", n_valid - s_valid, 1);
        check("t4_cks_cnt", n_cks - s_cks, 0);
        check("t4_hum2", int'(humidity), 'hC8);
        check("t4_tmp2", int'(temperature), 'h50);

        // 5a: start while busy is ignored
        repeat (60) @(negedge clk);
        n0 = n_oe_rise;
        pulse_start();
        wait_lvl(0, 1'b1, 10, "t5_oe_rise");
        pulse_start();
        wait_lvl(1, 1'b0, 100, "t5_busy_low");
        repeat (100) @(negedge clk);
        check("t5_single_launch", n_oe_rise - n0, 1);

        // 5b: start 10 cycles after completion launches once holdoff has run out
        n0 = n_oe_rise;
        pulse_start();
        wait_lvl(1, 1'b1, 10, "t5b_busy_high");
        wait_lvl(1, 1'b0, 100, "t5b_busy_low");
        repeat (9) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_lvl(0, 1'b1, 100, "t5b_pend_rise");
        check("t5b_pend_delay", oe_rise_cyc - busy_fall_cyc, HOLDOFF_CYC + 1);
        wait_lvl(1, 1'b0, 100, "t5b_busy_low2");
        repeat (100) @(negedge clk);
        check("t5b_launches", n_oe_rise - n0, 2);

        // 6: auto polling for 1300 cycles
        n0 = n_oe_rise; s_to = n_to;
        @(negedge clk);
        auto_en = 1'b1;
        repeat (1300) @(negedge clk);
        auto_en = 1'b0;
        #1;
        d  = n_oe_rise - n0;
        n1 = n_oe_rise;
        check("t6_count_3_4", int'(d >= 3 && d <= 4), 1);
        check("t6_spacing01", rise_at[n0+1] - rise_at[n0], POLL_CYC);
        check("t6_spacing12", rise_at[n0+2] - rise_at[n0+1], POLL_CYC);
        repeat (1000) @(negedge clk);
        check("t6_auto_off", n_oe_rise - n1, 0);
        check("t6_to_cnt", n_to - s_to, d);
        check("t6_oe_idle", int'(dht_oe), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
